// File: rtl/hps_link_pkg.sv
// Shared definitions for the HPS-side matrix-coprocessor link master:
// command-word field positions, matrix geometry, opcodes and FSM states.
package hps_link_pkg;

  localparam int VAL_A_LSB  = 0;
  localparam int VAL_B_LSB  = 8;
  localparam int OPCODE_LSB = 16;
  localparam int SIZE_LSB   = 19;
  localparam int SCALAR_LSB = 21;
  localparam int SRESET_BIT = 29;
  localparam int START_BIT  = 30;
  localparam int READY_BIT  = 31;
  localparam int ACK_BIT    = 31;

  localparam int         MATRIX_ELEMS = 25;
  localparam logic [4:0] LAST_IDX     = 5'd24;

  localparam logic [2:0] OP_ADD       = 3'd0;
  localparam logic [2:0] OP_SUB       = 3'd1;
  localparam logic [2:0] OP_MUL       = 3'd2;
  localparam logic [2:0] OP_SCALE     = 3'd3;
  localparam logic [2:0] OP_TRANSPOSE = 3'd4;
  localparam logic [2:0] OP_DET       = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_LD_SET   = 4'd2,
    ST_LD_HI    = 4'd3,
    ST_LD_LO    = 4'd4,
    ST_POLL_HI  = 4'd5,
    ST_POLL_GAP = 4'd6,
    ST_RD_LO    = 4'd7,
    ST_FIN_HI   = 4'd8,
    ST_FIN_LO   = 4'd9,
    ST_ERR      = 4'd10,
    ST_SRESET   = 4'd11
  } link_state_t;

  function automatic logic [31:0] pack_word(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] opcode,
    input logic [1:0] size,
    input logic [7:0] scalar,
    input logic       sreset,
    input logic       start,
    input logic       ready
  );
    logic [31:0] w;
    w = '0;
    w[VAL_A_LSB +: 8]  = a;
    w[VAL_B_LSB +: 8]  = b;
    w[OPCODE_LSB +: 3] = opcode;
    w[SIZE_LSB +: 2]   = size;
    w[SCALAR_LSB +: 8] = scalar;
    w[SRESET_BIT]      = sreset;
    w[START_BIT]       = start;
    w[READY_BIT]       = ready;
    return w;
  endfunction

endpackage

// File: rtl/link_ack_sync.sv
// Two-flop synchronizer bringing the responder's ack into the clk domain.
module link_ack_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hps_link_master.sv
// Link master: buffers two 5x5 int8 operand matrices, runs the full ready/ack
// sequence against the coprocessor control unit and streams the 25 results.
module hps_link_master
  import hps_link_pkg::*;
#(
  parameter int ACK_TIMEOUT   = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int START_CYCLES  = 4,
  parameter int POLL_GAP      = 8,
  parameter int MAX_POLLS     = 255,
  parameter int RESET_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_wr_en,
  input  logic [4:0]  op_wr_addr,
  input  logic [7:0]  op_wr_a,
  input  logic [7:0]  op_wr_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_opcode,
  input  logic [1:0]  cmd_size,
  input  logic [7:0]  cmd_scalar,
  input  logic        sreset_req,
  output logic        res_valid,
  output logic [4:0]  res_index,
  output logic [7:0]  res_data,
  output logic        done,
  output logic        error,
  output logic        busy,
  output logic [31:0] to_fpga,
  input  logic [31:0] from_fpga,
  output logic [3:0]  dbg_state
);

  // Handshake: ready rises only with ack_s low and fields settled; the
  // responder raises ack once it has consumed/produced the word; ready then
  // drops, and the next transfer starts only after ack returns low.
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] START_LAST  = 16'(START_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
  localparam logic [15:0] RESET_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] POLL_LIMIT  = 16'(MAX_POLLS);

  link_state_t state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] polls_q, polls_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  opcode_q;
  logic [1:0]  size_q;
  logic [7:0]  scalar_q;
  logic [15:0] buf_q [MATRIX_ELEMS];
  logic        ack_s;
  logic        accept, capture, finish, tmo;
  logic        res_valid_q, done_q, error_q;
  logic [4:0]  res_index_q;
  logic [7:0]  res_data_q;
  logic        unused_from_fpga;

  assign unused_from_fpga = ^from_fpga[30:8];

  link_ack_sync u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (from_fpga[ACK_BIT]),
    .q     (ack_s)
  );

  assign tmo = (cnt_q >= ACK_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    polls_d = polls_q;
    accept  = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_START;
        end else if (sreset_req) begin
          state_d = ST_SRESET;
        end
      end
      ST_START: begin
        if (cnt_q >= START_LAST) begin
          idx_d   = 5'd0;
          state_d = ST_LD_SET;
        end
      end
      ST_LD_SET: begin
        if (!ack_s && cnt_q >= SETTLE_LAST) state_d = ST_LD_HI;
        else if (tmo)                       state_d = ST_ERR;
      end
      ST_LD_HI: begin
        if (ack_s)    state_d = ST_LD_LO;
        else if (tmo) state_d = ST_ERR;
      end
      ST_LD_LO: begin
        if (!ack_s) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 5'd0;
            polls_d = 16'd0;
            state_d = ST_POLL_HI;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_LD_SET;
          end
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_POLL_HI: begin
        if (ack_s) begin
          capture = 1'b1;
          state_d = ST_RD_LO;
        end else if (tmo) begin
          // Only the first result may legitimately be slow: the coprocessor
          // is still computing, so retry instead of failing.
          if (idx_q == 5'd0 && polls_q < POLL_LIMIT) begin
            polls_d = polls_q + 16'd1;
            state_d = ST_POLL_GAP;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_POLL_GAP: begin
        if (cnt_q >= GAP_LAST) state_d = ST_POLL_HI;
      end
      ST_RD_LO: begin
        if (!ack_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_FIN_HI;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_POLL_HI;
          end
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_FIN_HI: begin
        if (ack_s)    state_d = ST_FIN_LO;
        else if (tmo) state_d = ST_ERR;
      end
      ST_FIN_LO: begin
        if (!ack_s) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:    state_d = ST_SRESET;
      ST_SRESET: if (cnt_q >= RESET_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      polls_q     <= '0;
      opcode_q    <= '0;
      size_q      <= '0;
      scalar_q    <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      for (int i = 0; i < MATRIX_ELEMS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      polls_q <= polls_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_q != '1)   cnt_q <= cnt_q + 16'd1;
      if (accept) begin
        opcode_q <= cmd_opcode;
        size_q   <= cmd_size;
        scalar_q <= cmd_scalar;
      end
      res_valid_q <= capture;
      if (capture) begin
        res_index_q <= idx_q;
        res_data_q  <= from_fpga[7:0];
      end
      done_q  <= finish;
      error_q <= (state_d == ST_ERR);
      if (state_q == ST_IDLE && op_wr_en && op_wr_addr <= LAST_IDX)
        buf_q[op_wr_addr] <= {op_wr_b, op_wr_a};
    end
  end

  // Outputs decode purely from registered state so async reset clears them at once.
  always_comb begin
    logic        fields_on, elem_on, sreset_on, start_on, ready_on;
    logic [15:0] elem;
    fields_on = 1'b0;
    elem_on   = 1'b0;
    sreset_on = 1'b0;
    start_on  = 1'b0;
    ready_on  = 1'b0;
    elem      = buf_q[idx_q];
    case (state_q)
      ST_START:   begin fields_on = 1'b1; start_on = 1'b1; end
      ST_LD_SET:  begin fields_on = 1'b1; elem_on = 1'b1; end
      ST_LD_HI:   begin fields_on = 1'b1; elem_on = 1'b1; ready_on = 1'b1; end
      ST_LD_LO:   begin fields_on = 1'b1; elem_on = 1'b1; end
      ST_POLL_HI: begin fields_on = 1'b1; ready_on = 1'b1; end
      ST_FIN_HI:  begin fields_on = 1'b1; ready_on = 1'b1; end
      ST_POLL_GAP, ST_RD_LO, ST_FIN_LO: fields_on = 1'b1;
      ST_SRESET:  sreset_on = 1'b1;
      default:    fields_on = 1'b0;
    endcase
    to_fpga = pack_word(elem_on ? elem[7:0] : 8'd0,
                        elem_on ? elem[15:8] : 8'd0,
                        fields_on ? opcode_q : 3'd0,
                        fields_on ? size_q : 2'd0,
                        fields_on ? scalar_q : 8'd0,
                        sreset_on, start_on, ready_on);
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_index = res_index_q;
  assign res_data  = res_data_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hps_link_master.sv
// Directed bench for hps_link_master with a behavioural coprocessor responder.
module tb_hps_link_master;
  import hps_link_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_wr_en;
  logic [4:0]  op_wr_addr;
  logic [7:0]  op_wr_a, op_wr_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [1:0]  cmd_size;
  logic [7:0]  cmd_scalar;
  logic        sreset_req;
  logic        res_valid;
  logic [4:0]  res_index;
  logic [7:0]  res_data;
  logic        done, error, busy;
  logic [31:0] to_fpga;
  logic [31:0] from_fpga;
  logic [3:0]  dbg_state;

  hps_link_master dut (
    .clk        (clk),
    .reset      (reset),
    .op_wr_en   (op_wr_en),
    .op_wr_addr (op_wr_addr),
    .op_wr_a    (op_wr_a),
    .op_wr_b    (op_wr_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_size   (cmd_size),
    .cmd_scalar (cmd_scalar),
    .sreset_req (sreset_req),
    .res_valid  (res_valid),
    .res_index  (res_index),
    .res_data   (res_data),
    .done       (done),
    .error      (error),
    .busy       (busy),
    .to_fpga    (to_fpga),
    .from_fpga  (from_fpga),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: expected {index, data} per result strobe
  logic [12:0] exp_q[$];
  int start_cnt, rdy_cnt, sr_cnt, done_cnt, error_cnt, res_cnt;

  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (to_fpga[30]) start_cnt++;
      if (to_fpga[31]) rdy_cnt++;
      if (to_fpga[29]) sr_cnt++;
      if (done)  done_cnt++;
      if (error) error_cnt++;
      if (res_valid) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          check("res_extra", {19'd0, res_index, res_data}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("res", {19'd0, res_index, res_data}, {19'd0, e});
        end
      end
    end
  end

  // behavioural responder: xfers 0..24 load, 25..49 results, 50 closing
  logic        resp_en = 1'b0;
  int          resp_xfer, resp_gaps, resp_delay, field_bad;
  int          resp_phase = 0;
  logic [12:0] exp_fields;
  logic [15:0] ld_rec [25];

  initial begin
    logic rdy, prev_rdy, hold;
    prev_rdy  = 1'b0;
    from_fpga = '0;
    forever begin
      @(negedge clk);
      rdy = to_fpga[31];
      if (!resp_en) begin
        from_fpga  = '0;
        resp_phase = 0;
      end else begin
        if (resp_phase == 0 && prev_rdy && !rdy && resp_xfer == 25) resp_gaps++;
        if (resp_phase == 0 && rdy) begin
          hold = (resp_xfer == 25 && resp_gaps < resp_delay);
          if (!hold && resp_xfer <= 50) begin
            if (to_fpga[28:16] != exp_fields) field_bad++;
            if (resp_xfer < 25) ld_rec[resp_xfer] = to_fpga[15:0];
            from_fpga[7:0] = (resp_xfer >= 25 && resp_xfer < 50) ? 8'(resp_xfer + 75) : 8'h00;
            from_fpga[31]  = 1'b1;
            resp_phase     = 1;
          end
        end else if (resp_phase == 1 && !rdy) begin
          from_fpga  = '0;
          resp_xfer++;
          resp_phase = 0;
        end
      end
      prev_rdy = rdy;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic op_write(input logic [4:0] addr, input logic [7:0] a, input logic [7:0] b);
    op_wr_en = 1'b1; op_wr_addr = addr; op_wr_a = a; op_wr_b = b;
    step(1);
    op_wr_en = 1'b0;
  endtask

  task automatic clear_counts();
    start_cnt = 0; rdy_cnt = 0; sr_cnt = 0; done_cnt = 0; error_cnt = 0; res_cnt = 0;
    resp_xfer = 0; resp_gaps = 0; field_bad = 0;
    for (int i = 0; i < 25; i++) ld_rec[i] = 16'hDEAD;
    exp_q.delete();
  endtask

  task automatic start_cmd(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] sc,
                           input logic with_sreset);
    cmd_opcode = op; cmd_size = sz; cmd_scalar = sc;
    exp_fields = {sc, sz, op};
    cmd_valid  = 1'b1;
    sreset_req = with_sreset;
    step(1);
    cmd_valid  = 1'b0;
    sreset_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
  endtask

  task automatic check_run(input string tag, input int gaps);
    step(10);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_error_cnt"}, error_cnt, 0);
    check({tag, "_res_cnt"}, res_cnt, 25);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_xfers"}, resp_xfer, 51);
    check({tag, "_field_bad"}, field_bad, 0);
    check({tag, "_gaps"}, resp_gaps, gaps);
    check({tag, "_start_cnt"}, start_cnt, 4);
    for (int i = 0; i < 25; i++)
      check($sformatf("%s_ld%0d", tag, i), {16'd0, ld_rec[i]}, {16'd0, 8'(2 * i), 8'(i)});
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_to_fpga_idle"}, to_fpga, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    op_wr_en = 1'b0; op_wr_addr = '0; op_wr_a = '0; op_wr_b = '0;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_size = '0; cmd_scalar = '0;
    sreset_req = 1'b0;
    exp_fields = '0;
    resp_delay = 0;
    clear_counts();
    step(3);
    // reset values
    check("rst_to_fpga", to_fpga, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_index", {27'd0, res_index}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    reset = 1'b0;
    step(2);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_dbg_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});

    // load A[i]=i, B[i]=2i; address 25 must be ignored
    for (int i = 0; i < 25; i++) op_write(5'(i), 8'(i), 8'(2 * i));
    op_write(5'd25, 8'hEE, 8'hEE);

    // normal operation
    clear_counts();
    for (int i = 0; i < 25; i++) exp_q.push_back({5'(i), 8'(100 + i)});
    resp_delay = 0;
    resp_en    = 1'b1;
    start_cmd(OP_MUL, 2'd3, 8'h5A, 1'b0);
    check("norm_start_bit", {31'd0, to_fpga[30]}, 32'd1);
    check("norm_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("norm_fields", {19'd0, to_fpga[28:16]}, {19'd0, 8'h5A, 2'd3, OP_MUL});
    wait_done(3000, "norm");
    check_run("norm", 0);
    resp_en = 1'b0;
    step(4);

    // slow coprocessor (3 missed polls), sreset colliding with command,
    // operand writes while busy must be dropped
    clear_counts();
    for (int i = 0; i < 25; i++) exp_q.push_back({5'(i), 8'(100 + i)});
    resp_delay = 3;
    resp_en    = 1'b1;
    start_cmd(OP_SCALE, 2'd1, 8'hC3, 1'b1);
    check("slow_start_wins", {30'd0, to_fpga[30:29]}, 32'd2);
    op_write(5'd0, 8'hFF, 8'hFF);
    op_write(5'd1, 8'hFF, 8'hFF);
    op_write(5'd24, 8'hFF, 8'hFF);
    wait_done(6000, "slow");
    check_run("slow", 3);
    check("slow_no_sreset", sr_cnt, 0);
    resp_en = 1'b0;
    step(4);

    // responder never acks: timeout in LD_HI
    clear_counts();
    exp_fields = '0;
    start_cmd(OP_ADD, 2'd0, 8'h01, 1'b0);
    n = 0;
    while (error_cnt == 0 && n < 1500) begin
      step(1);
      n++;
    end
    check("tmo_error_seen", error_cnt, 1);
    check("tmo_ready_cycles", rdy_cnt, 1024);
    step(6);
    check("tmo_sreset_cycles", sr_cnt, 4);
    check("tmo_error_once", error_cnt, 1);
    check("tmo_no_done", done_cnt, 0);
    check("tmo_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // standalone soft reset request
    clear_counts();
    sreset_req = 1'b1;
    step(1);
    sreset_req = 1'b0;
    check("srst_bit", {31'd0, to_fpga[29]}, 32'd1);
    step(6);
    check("srst_cycles", sr_cnt, 4);
    check("srst_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of result 10
    clear_counts();
    for (int i = 0; i < 25; i++) exp_q.push_back({5'(i), 8'(100 + i)});
    resp_delay = 0;
    resp_en    = 1'b1;
    start_cmd(OP_SUB, 2'd2, 8'h33, 1'b0);
    exp_fields = {8'h33, 2'd2, OP_SUB};
    n = 0;
    while (!(res_cnt == 10 && to_fpga[31]) && n < 3000) begin
      step(1);
      n++;
    end
    check("mid_reached_res10", {31'd0, res_cnt == 10 && to_fpga[31]}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_to_fpga", to_fpga, 32'd0);
    check("mid_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    resp_en = 1'b0;
    step(3);
    reset = 1'b0;
    exp_q.delete();
    step(20);
    check("mid_no_done", done_cnt, 0);
    check("mid_no_error", error_cnt, 0);
    check("mid_res_cnt", res_cnt, 10);
    check("mid_to_fpga_after", to_fpga, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hps_link_master.md
# hps_link_master

Hardware initiator for the HPS↔FPGA matrix-coprocessor link: drives the 32-bit command word that the coprocessor control unit consumes and reads back its 32-bit status/result word. It buffers two 25-element signed 8-bit operand matrices and runs the full ready/ack handshake sequence for one operation: start, 25 operand transfers, result polling, 25 result reads and a closing handshake. It then streams the results out. It sits on the HPS side of the parallel-I/O bridge, or in a test harness, in place of software bit-banging.

## Interface
- `ACK_TIMEOUT`, 1024: cycles to wait for any ack edge before declaring a timeout.
- `SETTLE_CYCLES`, 4: cycles data/fields are held stable before `to_fpga[31]` rises.
- `START_CYCLES`, 4: cycles `to_fpga[30]` (start) is held high.
- `POLL_GAP`, 8: cycles ready stays low between result-poll attempts.
- `MAX_POLLS`, 255: poll attempts for the first result before error.
- `RESET_CYCLES`, 4: cycles `to_fpga[29]` (remote soft reset) is held high.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `op_wr_en` in 1: operand write strobe; ignored unless idle.
- `op_wr_addr` in 5: element index 0–24; values 25–31 are ignored.
- `op_wr_a`, `op_wr_b` in 8 each: element values for A and B.
- `cmd_valid` in 1: start an operation.
- `cmd_ready` out 1: `state==IDLE`.
- `cmd_opcode` in 3, `cmd_size` in 2, `cmd_scalar` in 8: operation fields, latched on accept.
- `sreset_req` in 1: pulse requests a remote soft reset; accepted only when idle.
- `res_valid` out 1: one-cycle strobe per result element.
- `res_index` out 5: index of the result element.
- `res_data` out 8: value of the result element.
- `done` out 1: one-cycle pulse when an operation completes.
- `error` out 1: one-cycle pulse on timeout.
- `busy` out 1: not idle.
- `to_fpga` out 32: `[7:0]` A elem, `[15:8]` B elem, `[18:16]` opcode, `[20:19]` size, `[28:21]` scalar, `[29]` soft reset, `[30]` start, `[31]` ready.
- `from_fpga` in 32: `[31]` ack, `[7:0]` result byte; other bits ignored.

## Operation
- Reset values: `to_fpga` = 0; `res_valid`, `done`, `error`, `busy` = 0; `res_index`, `res_data` = 0; operand buffer cleared; state IDLE.
- Ack handling: `from_fpga[31]` passes through a 2-FF synchronizer to give `ack_s`. `from_fpga[7:0]` is sampled only in the cycle `ack_s` first reads 1. The byte is stable while raw ack is high.
- Handshake rule: ready rises only after ack_s=0 and fields have been stable for `SETTLE_CYCLES`. Ready falls the cycle after ack_s=1. The next transfer waits for ack_s=0.
- Timeout: in every wait state a counter reaching `ACK_TIMEOUT` triggers a timeout. The one exception is POLL_HI for result 0.
- State machine:
  - IDLE: accepting `cmd_valid` latches the fields and goes to START. `sreset_req` goes to SRESET.
  - START: start=1 for `START_CYCLES`, ready=0, then go to LD_SET with idx=0.
  - LD_SET: drive A/B[idx] for `SETTLE_CYCLES`, then go to LD_HI.
  - LD_HI: ready=1 and wait ack_s=1, then go to LD_LO.
  - LD_LO: ready=0 and wait ack_s=0. If idx=24, go to POLL_HI with idx=0; otherwise increment idx and go to LD_SET.
  - POLL_HI: ready=1.
    - On ack_s=1: capture the byte, strobe `res_valid`, go to RD_LO.
    - On timeout with idx=0: if polls < `MAX_POLLS`, go to POLL_GAP; otherwise go to ERR.
    - On timeout with idx>0: go to ERR.
  - POLL_GAP: ready=0 for `POLL_GAP` cycles, then go to POLL_HI.
  - RD_LO: ready=0 and wait ack_s=0. If idx=24, go to FIN_HI; otherwise increment idx and go to POLL_HI.
  - FIN_HI / FIN_LO: one closing handshake with no capture. Pulse `done` and go to IDLE.
  - ERR: pulse `error`, clear start/ready, then go to SRESET.
  - SRESET: bit29=1 for `RESET_CYCLES`, then go to IDLE.
- Field hold: opcode, size and scalar stay driven from START through FIN_LO, because the responder samples them continuously. They are zero in IDLE.
- Width rules: no arithmetic on data. `res_index` = idx. Operand writes while busy are dropped.
- Reset mid-operation: all outputs return to their reset values immediately and no `done` or `error` is produced. The responder may then need a soft reset, which is the user's choice.

## Timing
- `cmd_valid`→start=1: 1 cycle.
- `res_valid` lags the raw ack rise by 2–3 cycles (synchronizer plus register).
- `done` is asserted the cycle after FIN_LO sees ack_s=0.
- `cmd_ready` can be 1 in the same cycle as `done`+1.
- `sreset_req` and `cmd_valid` arriving together: the command wins.

## Structure
- Package `hps_link_pkg`:
  - field bit positions (`VAL_A_LSB` … `READY_BIT`);
  - `MATRIX_ELEMS`=25;
  - opcode constants;
  - state enum.
- Sub-module `link_ack_sync`: 2-FF synchronizer with async reset.
- Operand buffer: 25×16-bit register array inside the top module.

## Test plan
- Load A[i]=i, B[i]=2i against a behavioural responder model; it must record 25 transfers with A[24]=24, B[24]=48 and the opcode/size/scalar held constant throughout.
- Responder returns result[i]=i+100; `res_valid` fires 25 times in order, with index 0→24 and data 100→124, followed by exactly one `done` and the closing handshake.
- Processing delay of 3 polls before SENDING: exactly 3 POLL_GAP ready-low intervals occur, then results arrive normally with no `error`.
- Responder never acks in LD_HI: `error` pulses after `ACK_TIMEOUT` cycles, then bit29 is high for 4 cycles, then `cmd_ready`=1.
- Assert `reset` in the middle of result 10: `to_fpga`=0 and `res_valid`=0 at once, with no `done`.
- `op_wr_en` while busy: the buffer is unchanged, which the next operation's transfers confirm.
